register_file: RTL and testbench



---
 rtl/register_file.sv | 61 ++++++
 tb/tb_register_file.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// 32 x DATA_WIDTH register file: two combinational read ports, one synchronous write port, x0 reads zero.
// Optional write-first bypass on the read ports when REGFILE_BYPASS_EN is defined.
module register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] A1,
    input  logic [ADDR_WIDTH-1:0] A2,
    input  logic [ADDR_WIDTH-1:0] A3,
    input  logic                  WE3,
    input  logic [DATA_WIDTH-1:0] WD3,
    output logic [DATA_WIDTH-1:0] RD1,
    output logic [DATA_WIDTH-1:0] RD2
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_reg [DEPTH];
    logic [DATA_WIDTH-1:0] rd1_next;
    logic [DATA_WIDTH-1:0] rd2_next;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : gen_entry
            if (gi == 0) begin : gen_zero
                // x0 is a constant-zero flop so the read mux needs no special case for index 0.
                always_ff @(posedge clk) begin
                    regs_reg[gi] <= '0;
                end
            end else begin : gen_reg
                always_ff @(posedge clk) begin
                    if (!rst) begin
                        regs_reg[gi] <= '0;
                    end else if (WE3 && (A3 == ADDR_WIDTH'(gi))) begin
                        regs_reg[gi] <= WD3;
                    end
                end
            end
        end
    endgenerate

    always_comb begin
        rd1_next = regs_reg[A1];
        rd2_next = regs_reg[A2];
`ifdef REGFILE_BYPASS_EN
        if (WE3 && (A3 != '0) && (A1 == A3)) begin
            rd1_next = WD3;
        end
        if (WE3 && (A3 != '0) && (A2 == A3)) begin
            rd2_next = WD3;
        end
`else
`endif
    end

    // Outputs are held at zero during reset so the ALU sees A=B=0.
    assign RD1 = rst ? rd1_next : '0;
    assign RD2 = rst ? rd2_next : '0;

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed vector table, hand-written ALU sequence,
// then a randomized phase checked against a behavioural model through a scoreboard queue.
module tb_register_file;
    logic        clk;
    logic        rst;
    logic [4:0]  A1, A2, A3;
    logic        WE3;
    logic [31:0] WD3;
    logic [31:0] RD1, RD2;

    int total = 0;
    int bad   = 0;

    register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk(clk), .rst(rst), .A1(A1), .A2(A2), .A3(A3),
        .WE3(WE3), .WD3(WD3), .RD1(RD1), .RD2(RD2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic        we;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [4:0]  a3;
        logic [31:0] wd;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    typedef struct packed {
        logic [31:0] e1;
        logic [31:0] e2;
    } exp_t;

    localparam int NVEC = 17;
`ifdef REGFILE_BYPASS_EN
    localparam logic [31:0] RDW_EXP = 32'h7FFF_FFFF;
    localparam bit BYPASS = 1'b1;
`else
    localparam logic [31:0] RDW_EXP = 32'h0000_0001;
    localparam bit BYPASS = 1'b0;
`endif

    vec_t        vecs [NVEC];
    exp_t        sb [$];
    logic [31:0] model [32];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, req);
        end
    endtask

    // One cycle: drive after the falling edge, compare the combinational reads before the rising edge.
    task automatic cycle(input string name, input logic r, input logic we, input logic [4:0] a1,
                         input logic [4:0] a2, input logic [4:0] a3, input logic [31:0] wd,
                         input logic [31:0] e1, input logic [31:0] e2);
        exp_t e;
        @(negedge clk);
        rst = r; WE3 = we; A1 = a1; A2 = a2; A3 = a3; WD3 = wd;
        sb.push_back('{e1: e1, e2: e2});
        #1;
        e = sb.pop_front();
        check({name, ".rd1"}, RD1, e.e1);
        check({name, ".rd2"}, RD2, e.e2);
        $display("cyc rst=%0b we=%0b a1=%0d a2=%0d a3=%0d wd=%08h rd1=%08h rd2=%08h %s",
                 r, we, a1, a2, a3, wd, RD1, RD2, name);
    endtask

    function automatic logic [31:0] model_read(input logic r, input logic we, input logic [4:0] a,
                                               input logic [4:0] a3, input logic [31:0] wd);
        if (!r) return 32'h0;
        if (BYPASS && we && (a3 != 5'd0) && (a == a3)) return wd;
        return model[a];
    endfunction

    task automatic model_cycle(input string name, input logic r, input logic we, input logic [4:0] a1,
                               input logic [4:0] a2, input logic [4:0] a3, input logic [31:0] wd);
        logic [31:0] e1, e2;
        e1 = model_read(r, we, a1, a3, wd);
        e2 = model_read(r, we, a2, a3, wd);
        cycle(name, r, we, a1, a2, a3, wd, e1, e2);
        if (!r) begin
            for (int k = 0; k < 32; k++) model[k] = 32'h0;
        end else if (we && a3 != 5'd0) begin
            model[a3] = wd;
        end
    endtask

    function automatic logic [31:0] alu(input logic [2:0] ctl, input logic [31:0] a, input logic [31:0] b);
        case (ctl)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a & b;
            3'b011:  return a | b;
            default: return 32'h0;
        endcase
    endfunction

    initial begin
        logic [31:0] res;
        rst = 1'b0; WE3 = 1'b0; A1 = '0; A2 = '0; A3 = '0; WD3 = '0;

        vecs[0]  = '{1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0,         32'h0,         32'h0};
        vecs[1]  = '{1'b1, 1'b1, 5'd0, 5'd0, 5'd5, 32'hDEADBEEF,  32'h0,         32'h0};
        vecs[2]  = '{1'b1, 1'b0, 5'd5, 5'd5, 5'd0, 32'h0,         32'hDEADBEEF,  32'hDEADBEEF};
        vecs[3]  = '{1'b0, 1'b0, 5'd5, 5'd5, 5'd0, 32'h0,         32'h0,         32'h0};
        vecs[4]  = '{1'b1, 1'b0, 5'd5, 5'd5, 5'd0, 32'h0,         32'h0,         32'h0};
        vecs[5]  = '{1'b1, 1'b1, 5'd0, 5'd0, 5'd7, 32'h5,         32'h0,         32'h0};
        vecs[6]  = '{1'b1, 1'b0, 5'd7, 5'd7, 5'd0, 32'h0,         32'h5,         32'h5};
        vecs[7]  = '{1'b1, 1'b1, 5'd7, 5'd0, 5'd0, 32'hFFFFFFFF,  32'h5,         32'h0};
        vecs[8]  = '{1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0,         32'h0,         32'h0};
        vecs[9]  = '{1'b1, 1'b1, 5'd0, 5'd7, 5'd9, 32'h3,         32'h0,         32'h5};
        vecs[10] = '{1'b1, 1'b0, 5'd9, 5'd9, 5'd9, 32'h12345678,  32'h3,         32'h3};
        vecs[11] = '{1'b1, 1'b0, 5'd9, 5'd9, 5'd0, 32'h0,         32'h3,         32'h3};
        vecs[12] = '{1'b1, 1'b1, 5'd9, 5'd7, 5'd3, 32'h1,         32'h3,         32'h5};
        vecs[13] = '{1'b1, 1'b1, 5'd3, 5'd9, 5'd3, 32'h7FFFFFFF,  RDW_EXP,       32'h3};
        vecs[14] = '{1'b1, 1'b0, 5'd3, 5'd3, 5'd0, 32'h0,         32'h7FFFFFFF,  32'h7FFFFFFF};
        vecs[15] = '{1'b0, 1'b1, 5'd4, 5'd3, 5'd4, 32'h5,         32'h0,         32'h0};
        vecs[16] = '{1'b1, 1'b0, 5'd4, 5'd3, 5'd0, 32'h0,         32'h0,         32'h0};

        for (int i = 0; i < NVEC; i++) begin
            cycle($sformatf("vec%0d", i), vecs[i].rst, vecs[i].we, vecs[i].a1, vecs[i].a2,
                  vecs[i].a3, vecs[i].wd, vecs[i].e1, vecs[i].e2);
        end

        // ALU hookup: x1=5, x2=3, subtract.
        cycle("alu_w1", 1'b1, 1'b1, 5'd0, 5'd0, 5'd1, 32'h5, 32'h0, 32'h0);
        cycle("alu_w2", 1'b1, 1'b1, 5'd1, 5'd0, 5'd2, 32'h3, 32'h5, 32'h0);
        cycle("alu_rd", 1'b1, 1'b0, 5'd1, 5'd2, 5'd0, 32'h0, 32'h5, 32'h3);
        res = alu(3'b001, RD1, RD2);
        check("alu_result", res, 32'h2);
        check("alu_zero", {31'h0, res == 32'h0}, 32'h0);
        check("alu_negative", {31'h0, res[31]}, 32'h0);
        $display("alu ctl=001 a=%08h b=%08h result=%08h", RD1, RD2, res);

        // Model-checked phase: clear, fill every entry, reset, read back, then random traffic.
        for (int k = 0; k < 32; k++) model[k] = 32'h0;
        model_cycle("clr", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
        for (int k = 0; k < 32; k++) begin
            model_cycle($sformatf("fill%0d", k), 1'b1, 1'b1, 5'(k), 5'((k + 31) % 32), 5'(k),
                        $urandom() | 32'h1);
        end
        for (int k = 0; k < 32; k++) begin
            model_cycle($sformatf("rdall%0d", k), 1'b1, 1'b0, 5'(k), 5'(31 - k), 5'(k), $urandom());
        end
        model_cycle("rst_all", 1'b0, 1'b1, 5'd6, 5'd17, 5'd6, 32'hA5A5A5A5);
        for (int k = 0; k < 32; k++) begin
            model_cycle($sformatf("post_rst%0d", k), 1'b1, 1'b0, 5'(k), 5'(31 - k), 5'd0, 32'h0);
        end
        for (int n = 0; n < 200; n++) begin
            model_cycle($sformatf("rnd%0d", n), ($urandom_range(0, 29) != 0), 1'($urandom()),
                        5'($urandom()), 5'($urandom()), 5'($urandom()), $urandom());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
